// File: rtl/lsu_align_if.sv
// Request/response and bus-beat signal bundle for the load/store alignment unit.
// "slave" is the alignment unit itself; "master" is the core plus bus side driving it.
interface lsu_align_if;
  // core request
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  // core response
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // bus beat channel
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_wen;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic [1:0]  bus_resp;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
    input  bus_ready, bus_rvalid, bus_rdata, bus_resp,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output bus_valid, bus_wen, bus_addr, bus_wdata, bus_wstrb
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
    output bus_ready, bus_rvalid, bus_rdata, bus_resp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  bus_valid, bus_wen, bus_addr, bus_wdata, bus_wstrb
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit: turns a byte/half/word access at any byte address
// into one or two word-aligned bus beats, and reassembles and extends load data.
module lsu_align #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  lsu_align_if.slave  io
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    B0_REQ  = 3'd1,
    B0_WAIT = 3'd2,
    B1_REQ  = 3'd3,
    B1_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t      state_reg, state_next;

  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  size_reg;
  logic        wen_reg;
  logic        signed_reg;
  logic        err_reg;
  logic [31:0] beat0_reg;
  // only the low three bytes of the second beat can ever reach a load result
  logic [23:0] beat1_reg;

  // byte-lane mask of an access of the given size, before lane shifting
  function automatic logic [3:0] mask_of(input logic [1:0] size);
    case (size)
      2'd0:    mask_of = 4'b0001;
      2'd1:    mask_of = 4'b0011;
      default: mask_of = 4'b1111;
    endcase
  endfunction

  // true when the access spills past the end of its word
  function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
    logic [2:0] nbytes;
    case (size)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    crosses = (({1'b0, off} + nbytes) > 3'd4);
  endfunction

  logic        req_bad;
  logic        lat_cross;
  logic [31:0] beat0_addr;
  logic [31:0] beat1_addr;
  logic [7:0]  strb_wide;
  logic [63:0] wdata_wide;
  logic [31:0] ld_word;
  logic [31:0] ld_data;

  // request classification and beat field derivation from the latched request
  always_comb begin
    req_bad    = (io.req_size == 2'd3) ||
                 (!SPLIT_EN && crosses(io.req_addr[1:0], io.req_size));
    lat_cross  = crosses(addr_reg[1:0], size_reg);
    beat0_addr = {addr_reg[31:2], 2'b00};
    beat1_addr = beat0_addr + 32'd4;
    // low half feeds beat 0, high half feeds beat 1
    strb_wide  = {4'b0000, mask_of(size_reg)} << addr_reg[1:0];
    wdata_wide = {32'd0, wdata_reg} << {addr_reg[1:0], 3'b000};
  end

  // realign the captured beats to the request offset, then size and extend
  always_comb begin
    case (addr_reg[1:0])
      2'd0:    ld_word = beat0_reg;
      2'd1:    ld_word = {beat1_reg[7:0],  beat0_reg[31:8]};
      2'd2:    ld_word = {beat1_reg[15:0], beat0_reg[31:16]};
      default: ld_word = {beat1_reg[23:0], beat0_reg[31:24]};
    endcase
    case (size_reg)
      2'd0:    ld_data = {{24{signed_reg & ld_word[7]}},  ld_word[7:0]};
      2'd1:    ld_data = {{16{signed_reg & ld_word[15]}}, ld_word[15:0]};
      default: ld_data = ld_word;
    endcase
  end

  // state register; reset forces IDLE so bus_valid drops without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // next-state and all outputs, decoded from the current state
  always_comb begin
    state_next   = state_reg;
    io.req_ready = 1'b0;
    io.rsp_valid = 1'b0;
    io.rsp_rdata = 32'd0;
    io.rsp_err   = 1'b0;
    io.bus_valid = 1'b0;
    io.bus_wen   = 1'b0;
    io.bus_addr  = 32'd0;
    io.bus_wdata = 32'd0;
    io.bus_wstrb = 4'b0000;
    case (state_reg)
      IDLE: begin
        io.req_ready = 1'b1;
        if (io.req_valid) begin
          state_next = req_bad ? RESP : B0_REQ;
        end
      end
      B0_REQ: begin
        io.bus_valid = 1'b1;
        io.bus_wen   = wen_reg;
        io.bus_addr  = beat0_addr;
        io.bus_wdata = wen_reg ? wdata_wide[31:0] : 32'd0;
        io.bus_wstrb = wen_reg ? strb_wide[3:0] : 4'b0000;
        if (io.bus_ready) begin
          state_next = B0_WAIT;
        end
      end
      B0_WAIT: begin
        if (io.bus_rvalid) begin
          state_next = (lat_cross && (io.bus_resp == 2'd0)) ? B1_REQ : RESP;
        end
      end
      B1_REQ: begin
        io.bus_valid = 1'b1;
        io.bus_wen   = wen_reg;
        io.bus_addr  = beat1_addr;
        io.bus_wdata = wen_reg ? wdata_wide[63:32] : 32'd0;
        io.bus_wstrb = wen_reg ? strb_wide[7:4] : 4'b0000;
        if (io.bus_ready) begin
          state_next = B1_WAIT;
        end
      end
      B1_WAIT: begin
        if (io.bus_rvalid) begin
          state_next = RESP;
        end
      end
      RESP: begin
        io.rsp_valid = 1'b1;
        io.rsp_err   = err_reg;
        // failed accesses and stores return no data
        io.rsp_rdata = (wen_reg || err_reg) ? 32'd0 : ld_data;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // request latch, beat data capture and error accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      size_reg   <= 2'd0;
      wen_reg    <= 1'b0;
      signed_reg <= 1'b0;
      err_reg    <= 1'b0;
      beat0_reg  <= 32'd0;
      beat1_reg  <= 24'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (io.req_valid) begin
            addr_reg   <= io.req_addr;
            wdata_reg  <= io.req_wdata;
            size_reg   <= io.req_size;
            wen_reg    <= io.req_wen;
            signed_reg <= io.req_signed;
            err_reg    <= req_bad;
            beat0_reg  <= 32'd0;
            beat1_reg  <= 24'd0;
          end
        end
        B0_WAIT: begin
          if (io.bus_rvalid) begin
            beat0_reg <= io.bus_rdata;
            if (io.bus_resp != 2'd0) begin
              err_reg <= 1'b1;
            end
          end
        end
        B1_WAIT: begin
          if (io.bus_rvalid) begin
            beat1_reg <= io.bus_rdata[23:0];
            if (io.bus_resp != 2'd0) begin
              err_reg <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_align.md
LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 Parameter SPLIT_EN, default 1: 1 = a misaligned access is split into two bus beats; 0 = a misaligned access returns rsp_err with no bus access.
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  core has a load/store request.
REQ-005 req_ready  out  1  block can accept a request (high only in IDLE).
REQ-006 req_wen  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-justified.
REQ-009 req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  32  extended load data; 0 for stores.
REQ-013 rsp_err  out  1  qualified by rsp_valid: the access failed.
REQ-014 bus_valid  out  1  beat request toward the AXI interface.
REQ-015 bus_ready  in  1  beat request accepted.
REQ-016 bus_wen  out  1  beat is a write.
REQ-017 bus_addr  out  32  word-aligned beat address (bits [1:0] = 0).
REQ-018 bus_wdata  out  32  lane-shifted write data.
REQ-019 bus_wstrb  out  4  byte strobes; 0 for reads.
REQ-020 bus_rvalid  in  1  beat response (reads and writes).
REQ-021 bus_rdata  in  32  beat read data.
REQ-022 bus_resp  in  2  beat response code; nonzero = error.

Function
REQ-023 The FSM SHALL have the states IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT and RESP.
REQ-024 In IDLE, req_valid SHALL latch addr, wdata, size, wen and signed, then move to B0_REQ, or to RESP with the error flag set if size==3, or if the access crosses a word and SPLIT_EN==0.
REQ-025 Derived values: off = addr[1:0]; mask = 0001/0011/1111 for size 0/1/2; cross = (off + 2^size > 4).
REQ-026 Beat 0 SHALL drive: addr = {addr[31:2], 2'b00}; wstrb = (mask << off)[3:0]; wdata = wdata << 8*off.
REQ-027 Beat 1 SHALL drive: addr = beat-0 addr + 4, wrapping mod 2^32; wstrb = mask >> (4 - off); wdata = wdata >> 8*(4 - off).
REQ-028 In B*_REQ the block SHALL hold bus_valid and all beat fields stable until bus_ready, then move to the matching B*_WAIT state.
REQ-029 In B*_WAIT the block SHALL wait for bus_rvalid and capture bus_rdata.
REQ-030 From B0_WAIT the FSM SHALL go to B1_REQ if cross and no error, otherwise to RESP.
REQ-031 A nonzero bus_resp SHALL set the error flag, and no further beat SHALL be issued.
REQ-032 Load data: the 64-bit value {beat1, beat0} >> 8*off SHALL be truncated to 2^size bytes, then sign- or zero-extended per req_signed.
REQ-033 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-034 rsp_rdata and rsp_err SHALL be valid only in the rsp_valid cycle and 0 otherwise.
REQ-035 Latency: with bus_ready and bus_rvalid each arriving the first cycle they are sampled, an aligned access SHALL accept at cycle 0, drive bus_valid at 1, see rvalid at 2 and pulse rsp_valid at 3.
REQ-036 A split access with the same bus timing SHALL pulse rsp_valid at cycle 5.
REQ-037 bus_rvalid outside a B*_WAIT state SHALL be ignored.
REQ-038 req_valid outside IDLE SHALL be ignored, since req_ready is low outside IDLE.

Reset
REQ-039 While reset is high, the state SHALL be IDLE, and req_ready SHALL be 1.
REQ-040 While reset is high, every other output and all latched registers SHALL be 0.
REQ-041 Reset asserted mid-transaction SHALL drop bus_valid immediately (asynchronously), with no rsp_valid for the aborted request.

Verification
REQ-042 Store byte, addr 0x80000003, wdata 0xAB -> one beat: addr 0x80000000, wstrb 1000, wdata 0xAB000000; rsp_valid with rsp_err=0.
REQ-043 Signed half load, addr 0x80000002, bus_rdata 0x80FF1234 -> rsp_rdata 0xFFFF80FF at cycle 3.
REQ-044 SPLIT_EN=1, word load at 0x80000001, beat data 0x44332211 then 0x88776655 -> beats at 0x80000000 and 0x80000004; rsp_rdata 0x55443322.
REQ-045 Split store, word 0xDDCCBBAA at 0x80000003 -> beat 0 wstrb 1000, wdata 0xAA000000; beat 1 wstrb 0111, wdata 0x00DDCCBB.
REQ-046 Size 3 request, or bus_resp=2 on beat 0 of a split access -> rsp_err=1 and no beat 1.
REQ-047 Reset pulsed while in B0_REQ with bus_ready low -> bus_valid falls in the same cycle; req_ready=1 after release.
